clkspec_addclient: RTL and testbench

//  Requester-side endpoint for the clocked-spec shared-adder service: issues a request token,

---
 rtl/clkspec_pkg.sv | 17 +
 rtl/clkspec_lfsr_n.sv | 23 ++
 rtl/clkspec_addclient.sv | 127 ++++++++++++
 tb/tb_clkspec_addclient.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clkspec_pkg.sv
// clkspec_pkg: shared state encoding, LFSR tap masks and rotate helper for the adder client
package clkspec_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_DATA, ST_RESP, ST_DONE} state_t;

   localparam logic [3:0] LFSR_TAPS_4 = 4'b1001;
   localparam logic [7:0] LFSR_TAPS_8 = 8'b10111000;

   function automatic logic [7:0] lfsr_taps(input int w);
      return (w == 8) ? LFSR_TAPS_8 : {4'b0000, LFSR_TAPS_4};
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v, input int w);
      return (w == 8) ? {v[6:0], v[7]} : {4'b0000, v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/clkspec_lfsr_n.sv
// clkspec_lfsr_n: shift-left Fibonacci LFSR, reloadable with SEED, advanced on demand
module clkspec_lfsr_n
   import clkspec_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             adv,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   // reload on start, otherwise step once per completed operation
   always_ff @(posedge clk or negedge reset)
      if (!reset) q <= SEED;
      else if (load) q <= SEED;
      else if (adv) q <= {q[WIDTH-2:0], ^(q & TAPS)};

endmodule

// File: rtl/clkspec_addclient.sv
// clkspec_addclient: self-checking requester for the shared adder (request, operands, result).
// Optional result watchdog enabled by defining CLKSPEC_CLIENT_TIMEOUT_EN.
module clkspec_addclient
   import clkspec_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter int               NUM_OPS = 8,
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
   parameter int               TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             r,
   input  logic             r_ack,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             d_v,
   input  logic             d_ack,
   input  logic [WIDTH-1:0] y,
   input  logic             y_v,
   output logic             y_ack,
   output logic             busy,
   output logic             done,
   output logic [7:0]       op_cnt,
   output logic [7:0]       err_cnt,
   output logic             timeout
);

   state_t           state;
   logic [WIDTH-1:0] lfsr_q, exp_sum;
   logic [7:0]       err_inc;
   logic             load, adv, last, expired;

   assign load    = (state == ST_IDLE) && start;
   assign adv     = (state == ST_RESP) && y_v;
   assign last    = (op_cnt == 8'(NUM_OPS - 1));
   assign err_inc = err_cnt + {7'd0, err_cnt != 8'hFF};

   clkspec_lfsr_n #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
      .clk(clk), .reset(reset), .load(load), .adv(adv), .q(lfsr_q)
   );

`ifdef CLKSPEC_CLIENT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;

   assign expired = (state == ST_RESP) && !y_v && (wait_cnt == TW'(TIMEOUT - 1));

   // wait counter runs only in RESP; the sticky flag clears on a new run
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         wait_cnt <= (state == ST_RESP) ? wait_cnt + 1'b1 : '0;
         timeout  <= load ? 1'b0 : (timeout | expired);
      end
`else
   assign expired = 1'b0;
   assign timeout = 1'b0;
`endif

   // client FSM with registered handshake/status outputs, result compare and counters
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= ST_IDLE;
         r       <= 1'b0;
         d_v     <= 1'b0;
         y_ack   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         a       <= '0;
         b       <= '0;
         exp_sum <= '0;
         op_cnt  <= '0;
         err_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               state   <= ST_REQ;
               r       <= 1'b1;
               busy    <= 1'b1;
               op_cnt  <= '0;
               err_cnt <= '0;
            end
            ST_REQ: if (r_ack) begin
               state <= ST_DATA;
               r     <= 1'b0;
               d_v   <= 1'b1;
               a     <= lfsr_q;
               b     <= WIDTH'(rotl1(8'(lfsr_q), WIDTH));
            end
            ST_DATA: if (d_ack) begin
               state   <= ST_RESP;
               d_v     <= 1'b0;
               y_ack   <= 1'b1;
               exp_sum <= a + b;
            end
            ST_RESP: if (y_v) begin
               op_cnt <= op_cnt + 8'd1;
               y_ack  <= 1'b0;
               if (y != exp_sum) err_cnt <= err_inc;
               if (last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= ST_REQ;
                  r     <= 1'b1;
               end
            end else if (expired) begin
               state   <= ST_DONE;
               err_cnt <= err_inc;
               y_ack   <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            ST_DONE: if (!start) begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end

endmodule

// File: tb/tb_clkspec_addclient.sv
// tb_clkspec_addclient: randomized handshake bench with an operand/result scoreboard
module tb_clkspec_addclient;

   localparam int NOPS = 20;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       bad;
   } op_t;

   logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic       r_ack = 1'b0, d_ack = 1'b0, y_v = 1'b0;
   logic [3:0] y = 4'h0;
   logic       r, d_v, y_ack, busy, done, timeout;
   logic [3:0] a, b;
   logic [7:0] op_cnt, err_cnt;

   int checks = 0, failures = 0;
   int r_pct = 100, d_pct = 100, y_pct = 100;
   op_t opq[$];
   op_t rq[$];
   logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                            4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

   clkspec_addclient #(.WIDTH(4), .NUM_OPS(NOPS), .SEED(4'h1), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .r(r), .r_ack(r_ack), .a(a), .b(b),
      .d_v(d_v), .d_ack(d_ack), .y(y), .y_v(y_v), .y_ack(y_ack), .busy(busy),
      .done(done), .op_cnt(op_cnt), .err_cnt(err_cnt), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, got, want, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #4;
   endtask

   // adder-side responder: random acks, result computed from the expected operand pair
   initial forever begin
      @(negedge clk);
      r_ack = int'($urandom_range(99)) < r_pct;
      d_ack = int'($urandom_range(99)) < d_pct;
      y_v   = int'($urandom_range(99)) < y_pct;
      y     = (rq.size() != 0) ? (rq[0].a + rq[0].b) ^ {3'b000, rq[0].bad} : 4'($urandom);
   end

   // monitor: pops the scoreboard on each transfer and checks handshake rules
   initial begin
      op_t  o;
      int   m_ops = 0, m_err = 0;
      logic pend = 0, p_r = 0, p_rx = 0, p_dv = 0, p_dx = 0, p_busy = 0;
      logic [3:0] p_a = 0, p_b = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            {pend, p_r, p_rx, p_dv, p_dx, p_busy} = '0;
         end else begin
            if (!p_busy && busy) begin
               m_ops = 0;
               m_err = 0;
            end
            if (pend) begin
               chk("op_cnt_step", op_cnt, m_ops);
               chk("err_cnt_step", err_cnt, m_err);
               pend = 0;
            end
            if (p_r && !p_rx) chk("r_hold", r, 1);
            if (p_dv && !p_dx) begin
               chk("dv_hold", d_v, 1);
               chk("a_hold", a, p_a);
               chk("b_hold", b, p_b);
            end
            if (r || d_v) chk("yack_outside_resp", y_ack, 0);
            if (d_v && d_ack) begin
               chk("opq_avail", opq.size() != 0, 1);
               if (opq.size() != 0) begin
                  o = opq.pop_front();
                  chk("a", a, o.a);
                  chk("b", b, o.b);
               end
            end
            if (y_v && y_ack) begin
               chk("rq_avail", rq.size() != 0, 1);
               if (rq.size() != 0) begin
                  o = rq.pop_front();
                  m_ops++;
                  if (o.bad && m_err != 255) m_err++;
                  pend = 1;
               end
            end
            p_r = r; p_rx = r & r_ack; p_dv = d_v; p_dx = d_v & d_ack;
            p_a = a; p_b = b; p_busy = busy;
         end
      end
   end

   task automatic issue_run(input bit corrupt, output int exp_err);
      exp_err = 0;
      for (int k = 0; k < NOPS; k++) begin
         op_t o;
         o.a   = seq[k % 15];
         o.b   = 4'((int'(o.a) * 2) % 16 + int'(o.a) / 8);
         o.bad = corrupt && ($urandom_range(3) == 0);
         opq.push_back(o);
         rq.push_back(o);
         exp_err += int'(o.bad);
      end
      start = 1'b1;
   endtask

   task automatic finish_run(input int exp_err);
      int n = 0;
      while (!done && n < 3000) begin
         step(1);
         n++;
      end
      chk("done", done, 1);
      chk("busy_in_done", busy, 0);
      chk("op_cnt_end", op_cnt, NOPS);
      chk("err_cnt_end", err_cnt, exp_err);
      chk("queues_drained", opq.size() + rq.size(), 0);
      start = 1'b0;
      step(2);
      chk("done_cleared", done, 0);
   endtask

   initial begin
      int e, n;
      step(2);
      chk("rst_r", r, 0);
      chk("rst_dv", d_v, 0);
      chk("rst_yack", y_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_counts", {op_cnt, err_cnt}, 0);
      chk("rst_ab", {a, b}, 0);
      reset = 1'b1;
      step(2);
      issue_run(0, e);
      finish_run(e);
      r_pct = 50; d_pct = 50; y_pct = 50;
      issue_run(1, e);
      finish_run(e);
      r_pct = 30; d_pct = 30; y_pct = 30;
      issue_run(1, e);
      finish_run(e);
      r_pct = 100; d_pct = 0; y_pct = 100;
      issue_run(0, e);
      n = 0;
      while (!d_v && n < 200) begin
         step(1);
         n++;
      end
      chk("dv_before_reset", d_v, 1);
      reset = 1'b0;
      #1;
      chk("arst_r", r, 0);
      chk("arst_dv", d_v, 0);
      chk("arst_busy", busy, 0);
      chk("arst_a", a, 0);
      start = 1'b0;
      step(2);
      reset = 1'b1;
      opq.delete();
      rq.delete();
      d_pct = 100;
      step(1);
      issue_run(0, e);
      finish_run(e);
      y_pct = 0;
      issue_run(0, e);
      n = 0;
      while (!y_ack && n < 200) begin
         step(1);
         n++;
      end
      chk("resp_reached", y_ack, 1);
`ifdef CLKSPEC_CLIENT_TIMEOUT_EN
      step(15);
      chk("timeout_early", timeout, 0);
      step(1);
      chk("timeout_set", timeout, 1);
      chk("timeout_err", err_cnt, 1);
      chk("timeout_done", done, 1);
      chk("timeout_ops", op_cnt, 0);
`else
      step(100);
      chk("resp_wait_yack", y_ack, 1);
      chk("resp_wait_busy", busy, 1);
      chk("resp_wait_timeout", timeout, 0);
      chk("resp_wait_ops", op_cnt, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
